lzc: RTL and testbench

LZC -- requirements
Module: lzc

---
 rtl/lzc_pkg.sv | 17 +
 rtl/lzc_node.sv | 20 ++
 rtl/lzc.sv | 96 +++++++++
 tb/tb_lzc.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the leading-zero counter.
package lzc_pkg;

    localparam int LZC_WIDTH_DEF = 24;
    localparam int LZC_CW_DEF    = 5;

    // Smallest r with 2**r >= x+1, i.e. bits needed to represent 0..x.
    function automatic int lzc_clog2p1(input int x);
        for (int r = 0; r < 32; r++) begin
            if ((64'd1 << r) >= 64'(x) + 64'd1) begin
                return r;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/lzc_node.sv
// One merge node of the LZC tree: combines the (valid, count) pairs of two halves.
module lzc_node #(
    parameter int TW   = 6,
    parameter int HALF = 1
) (
    input  logic          left_valid,
    input  logic [TW-1:0] left_count,
    input  logic          right_valid,
    input  logic [TW-1:0] right_count,
    output logic          parent_valid,
    output logic [TW-1:0] parent_count
);

    localparam logic [TW-1:0] HALF_C = TW'(HALF);

    assign parent_valid = left_valid | right_valid;
    // A one in the left half decides the count; otherwise the whole left half is zeros.
    assign parent_count = left_valid ? left_count : HALF_C + right_count;

endmodule

// File: rtl/lzc.sv
// Leading-zero counter built as a balanced tree of lzc_node merges.
// Define LZC_OUTREG_EN to register outputs (1-cycle latency); default is combinational.
module lzc
    import lzc_pkg::*;
#(
    parameter int WIDTH = LZC_WIDTH_DEF,
    parameter int CW    = LZC_CW_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [CW-1:0]    o_lzc,
    output logic             o_zero
);

    localparam int LOG_P = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
    localparam int P     = 1 << LOG_P;
    localparam int TW    = LOG_P + 1;

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("lzc: WIDTH must be in 2..64");
    end
    if (CW < lzc_clog2p1(WIDTH)) begin : g_cw_check
        $error("lzc: CW too small to represent WIDTH");
    end

    // Zero padding goes on the LSB side so the leading-zero count is unchanged.
    logic [P-1:0] padded;
    assign padded = P'(i_data) << (P - WIDTH);

    genvar lv, j;
    for (lv = 0; lv <= LOG_P; lv++) begin : g_lvl
        localparam int N = P >> lv;
        logic [N-1:0]  v;
        logic [TW-1:0] c [N];

        if (lv == 0) begin : g_leaf
            for (j = 0; j < N; j++) begin : g_bit
                assign v[j] = padded[P-1-j];
                assign c[j] = '0;
            end
        end else begin : g_merge
            for (j = 0; j < N; j++) begin : g_node
                lzc_node #(
                    .TW   (TW),
                    .HALF (1 << (lv - 1))
                ) u_node (
                    .left_valid   (g_lvl[lv-1].v[2*j]),
                    .left_count   (g_lvl[lv-1].c[2*j]),
                    .right_valid  (g_lvl[lv-1].v[2*j+1]),
                    .right_count  (g_lvl[lv-1].c[2*j+1]),
                    .parent_valid (v[j]),
                    .parent_count (c[j])
                );
            end
        end
    end

    logic          root_valid;
    logic [TW-1:0] root_count;
    logic [CW-1:0] lzc_c;
    logic          zero_c;

    assign root_valid = g_lvl[LOG_P].v[0];
    assign root_count = g_lvl[LOG_P].c[0];
    // An empty tree counts P-1 through the padding; report WIDTH instead.
    assign lzc_c  = root_valid ? CW'(root_count) : CW'(WIDTH);
    assign zero_c = ~root_valid;

`ifdef LZC_OUTREG_EN
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_lzc   <= '0;
            o_zero  <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_lzc  <= lzc_c;
                o_zero <= zero_c;
            end
        end
    end
`else
    assign o_valid = i_valid;
    assign o_lzc   = lzc_c;
    assign o_zero  = zero_c;

    logic unused_clk_rst;
    assign unused_clk_rst = i_clk ^ i_reset_n;
`endif

endmodule

// File: tb/tb_lzc.sv
// Scoreboard bench for lzc (WIDTH=24, CW=5); follows LZC_OUTREG_EN for expected latency.
module tb_lzc;

    localparam int WIDTH = 24;
    localparam int CW    = 5;

    typedef struct {
        logic [CW-1:0] lzc;
        logic          zero;
    } exp_t;

    logic             i_clk;
    logic             i_reset_n;
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic [CW-1:0]    o_lzc;
    logic             o_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    lzc #(.WIDTH(WIDTH), .CW(CW)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .o_lzc     (o_lzc),
        .o_zero    (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: walk down from the MSB counting zeros until the first one.
    function automatic exp_t ref_model(input logic [WIDTH-1:0] d);
        exp_t e;
        int   n = 0;
        while (n < WIDTH && d[WIDTH-1-n] == 1'b0) n++;
        e.lzc  = CW'(n);
        e.zero = (d == '0);
        return e;
    endfunction

    // One cycle of stimulus, applied just after the rising edge.
    task automatic drive(input logic [WIDTH-1:0] d, input logic v);
        @(posedge i_clk);
        #1;
        i_valid = v;
        i_data  = d;
        if (v) exp_q.push_back(ref_model(d));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("lzc", o_lzc, e.lzc);
                    check("zero", o_zero, e.zero);
                end
            end
        end
    end

    initial begin : stimulus
        logic [WIDTH-1:0] w;
        int               budget;

        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        #3;
        check("reset_valid", o_valid, 0);
`ifdef LZC_OUTREG_EN
        check("reset_lzc", o_lzc, 0);
        check("reset_zero", o_zero, 0);
`endif
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        drive(24'h800000, 1'b1);
        drive(24'h000001, 1'b1);
        drive(24'h001000, 1'b1);
        drive(24'h000000, 1'b1);
        drive(24'h00FFFF, 1'b1);
        drive(24'h000000, 1'b0);

        drive(24'h400000, 1'b1);
        drive(24'h000003, 1'b1);
        drive(24'h0000FF, 1'b1);
        drive(24'h000001, 1'b0);
        drive(24'hFFFFFF, 1'b0);
        #1;
        check("idle_valid", o_valid, 0);
`ifdef LZC_OUTREG_EN
        check("hold_lzc", o_lzc, 16);
        check("hold_zero", o_zero, 0);
`endif

        for (int k = 0; k < WIDTH; k++) begin
            w = '0;
            w[k] = 1'b1;
            drive(w, 1'b1);
        end

        // Reset mid-stream: registered build drops the in-flight word immediately.
        drive(24'h000100, 1'b1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        #1;
        i_reset_n = 1'b0;
        #1;
`ifdef LZC_OUTREG_EN
        check("midrst_valid", o_valid, 0);
        check("midrst_lzc", o_lzc, 0);
        check("midrst_zero", o_zero, 0);
        exp_q.delete();
`else
        check("midrst_valid", o_valid, 0);
        check("midrst_lzc", o_lzc, ref_model(24'h000100).lzc);
`endif
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            w = WIDTH'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) w = '0;
            drive(w, ($urandom_range(0, 3) != 0));
        end
        drive(24'h000000, 1'b0);

        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge i_clk);
            budget--;
        end
        check("drain_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
